// File: rtl/serial_demux_pkg.sv
// ---------------------------------------------------------------------------
// serial_demux_pkg
// Shared definitions for the serial frame demultiplexer:
//   demuxState_t : frame-parser state encoding (IDLE, PORT, LEN, DATA)
//   bitCntWidth  : width of the field bit counter, wide enough for either
//                  the port-address field or the length field
// ---------------------------------------------------------------------------
package serial_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PORT = 2'b01,
    LEN  = 2'b10,
    DATA = 2'b11
  } demuxState_t;

  function automatic int bitCntWidth(input int portW, input int lenW);
    return (portW > lenW) ? portW : lenW;
  endfunction

endpackage

// File: rtl/serial_demux_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_demux_ctrl_if
// Bundles the serial-side inputs and the per-channel outputs of the
// demultiplexer.
//   clk_en        : bit strobe from the receiver front end
//   ser_in        : serial data, idle level 1
//   abort         : synchronous abort, honoured on every clock edge
//   ser_out       : registered payload bit per channel
//   ser_out_valid : one-clock pulse per delivered payload bit
//   port_sel      : port address of the current or last frame
//   busy          : frame in progress
//   done          : one-clock pulse on frame completion
// Modports: master drives the serial side, slave is the demultiplexer.
// ---------------------------------------------------------------------------
interface serial_demux_ctrl_if #(
  parameter int PORT_W = 2
);

  localparam int NPORTS = 2 ** PORT_W;

  logic              clk_en;
  logic              ser_in;
  logic              abort;
  logic [NPORTS-1:0] ser_out;
  logic [NPORTS-1:0] ser_out_valid;
  logic [PORT_W-1:0] port_sel;
  logic              busy;
  logic              done;

  modport master (
    output clk_en, ser_in, abort,
    input  ser_out, ser_out_valid, port_sel, busy, done
  );

  modport slave (
    input  clk_en, ser_in, abort,
    output ser_out, ser_out_valid, port_sel, busy, done
  );

endinterface

// File: rtl/serial_demux_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// serial_demux_fsm
// Frame-parser state machine: state register, field bit counter and the
// registered frame-done pulse.
//   clk        : system clock
//   i_rstN     : asynchronous active-low reset (already release-synchronised)
//   i_clkEn    : bit strobe
//   i_serIn    : serial input (start-bit detection)
//   i_abort    : synchronous abort, overrides the bit strobe
//   i_lenZero  : length field assembled this edge is zero
//   i_lenLast  : remaining payload count is one
//   o_state    : current parser state
//   o_done     : one-clock frame-completion pulse
// ---------------------------------------------------------------------------
module serial_demux_fsm
  import serial_demux_pkg::*;
#(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic        clk,
  input  logic        i_rstN,
  input  logic        i_clkEn,
  input  logic        i_serIn,
  input  logic        i_abort,
  input  logic        i_lenZero,
  input  logic        i_lenLast,
  output demuxState_t o_state,
  output logic        o_done
);

  localparam int CNT_W = bitCntWidth(PORT_W, LEN_W);

  demuxState_t r_state;
  demuxState_t w_nextState;
  logic [CNT_W-1:0] r_bitCnt;
  logic [CNT_W-1:0] w_nextBitCnt;
  logic             r_done;
  logic             w_nextDone;

  // Next-state logic. Abort wins over the bit strobe; without a strobe
  // everything holds and the done pulse falls back to 0.
  always_comb begin
    w_nextState  = r_state;
    w_nextBitCnt = r_bitCnt;
    w_nextDone   = 1'b0;
    if (i_abort) begin
      w_nextState  = IDLE;
      w_nextBitCnt = '0;
    end else if (i_clkEn) begin
      unique case (r_state)
        IDLE: begin
          if (!i_serIn) begin
            w_nextState  = PORT;
            w_nextBitCnt = '0;
          end
        end
        PORT: begin
          if (r_bitCnt == CNT_W'(PORT_W - 1)) begin
            w_nextState  = LEN;
            w_nextBitCnt = '0;
          end else begin
            w_nextBitCnt = r_bitCnt + CNT_W'(1);
          end
        end
        LEN: begin
          if (r_bitCnt == CNT_W'(LEN_W - 1)) begin
            w_nextBitCnt = '0;
            // A zero-length frame completes on its last length bit.
            if (i_lenZero) begin
              w_nextState = IDLE;
              w_nextDone  = 1'b1;
            end else begin
              w_nextState = DATA;
            end
          end else begin
            w_nextBitCnt = r_bitCnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (i_lenLast) begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
          end
        end
      endcase
    end
  end

  // State, counter and done registers.
  always_ff @(posedge clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_bitCnt <= w_nextBitCnt;
      r_done   <= w_nextDone;
    end
  end

  assign o_state = r_state;
  assign o_done  = r_done;

endmodule

// File: rtl/serial_demux_ctrl.sv
// ---------------------------------------------------------------------------
// serial_demux_ctrl
// Serial frame demultiplexer. A frame is: start bit (0), PORT_W address
// bits, LEN_W length bits, then LEN payload bits, all MSB-first and each
// qualified by clk_en. Payload bits are routed to channel port_sel.
//   clk   : system clock
//   reset : asynchronous active-low reset, release synchronised internally
//   bus   : serial_demux_ctrl_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module serial_demux_ctrl
  import serial_demux_pkg::*;
#(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4
) (
  input logic               clk,
  input logic               reset,
  serial_demux_ctrl_if.slave bus
);

  localparam int NPORTS = 2 ** PORT_W;

  logic [1:0]        r_rstSync;
  logic              w_rstN;
  demuxState_t       w_state;
  logic              w_done;
  logic              w_step;
  logic              w_dataStep;
  logic [LEN_W-1:0]  w_lenAssembled;
  logic              w_lenZero;
  logic              w_lenLast;
  logic [NPORTS-1:0] w_validHot;
  logic [PORT_W-1:0] r_portSel;
  logic [LEN_W-1:0]  r_lenCnt;
  logic [NPORTS-1:0] r_serOut;
  logic [NPORTS-1:0] r_serOutValid;

  // Reset asserts immediately and releases two clocks later, so the parser
  // never sees a partially released reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  assign w_step         = bus.clk_en & ~bus.abort;
  assign w_dataStep     = w_step && (w_state == DATA);
  assign w_lenAssembled = LEN_W'({r_lenCnt, bus.ser_in});
  assign w_lenZero      = (w_lenAssembled == '0);
  assign w_lenLast      = (r_lenCnt == LEN_W'(1));
  assign w_validHot     = NPORTS'(1) << r_portSel;

  serial_demux_fsm #(
    .PORT_W (PORT_W),
    .LEN_W  (LEN_W)
  ) u_fsm (
    .clk       (clk),
    .i_rstN    (w_rstN),
    .i_clkEn   (bus.clk_en),
    .i_serIn   (bus.ser_in),
    .i_abort   (bus.abort),
    .i_lenZero (w_lenZero),
    .i_lenLast (w_lenLast),
    .o_state   (w_state),
    .o_done    (w_done)
  );

  // Port-address shifter; holds across abort so the last address stays visible.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_portSel <= '0;
    end else if (w_step && (w_state == PORT)) begin
      r_portSel <= PORT_W'({r_portSel, bus.ser_in});
    end
  end

  // Length shifter in LEN, payload down-counter in DATA; abort clears it.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_lenCnt <= '0;
    end else if (bus.abort) begin
      r_lenCnt <= '0;
    end else if (bus.clk_en) begin
      case (w_state)
        LEN:     r_lenCnt <= w_lenAssembled;
        DATA:    r_lenCnt <= r_lenCnt - LEN_W'(1);
        default: r_lenCnt <= r_lenCnt;
      endcase
    end
  end

  // Per-channel payload registers and their one-clock valid pulses.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_serOut      <= '0;
      r_serOutValid <= '0;
    end else begin
      r_serOutValid <= w_dataStep ? w_validHot : '0;
      if (w_dataStep) begin
        r_serOut[r_portSel] <= bus.ser_in;
      end
    end
  end

  assign bus.ser_out       = r_serOut;
  assign bus.ser_out_valid = r_serOutValid;
  assign bus.port_sel      = r_portSel;
  assign bus.busy          = (w_state != IDLE);
  assign bus.done          = w_done;

endmodule

// File: tb/tb_serial_demux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_demux_ctrl
// Scoreboard bench: frame senders push expected valid/done events into a
// queue; a monitor pops and compares whenever the DUT pulses valid or done.
// ---------------------------------------------------------------------------
module tb_serial_demux_ctrl;

  localparam int PORT_W = 2;
  localparam int LEN_W  = 4;
  localparam int NPORTS = 4;

  typedef struct {
    bit   isDone;
    int   port;
    logic bitVal;
  } expEvent_t;

  logic clk = 1'b0;
  logic reset;
  expEvent_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_demux_ctrl_if #(.PORT_W(PORT_W)) bus ();

  serial_demux_ctrl #(
    .PORT_W (PORT_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one sample per clock, just after the active edge.
  initial begin
    expEvent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ser_out_valid != '0) begin
        checkOutput("validOneHot", 32'($countones(bus.ser_out_valid)), 32'd1);
        if (expQ.size() == 0 || expQ[0].isDone) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedValid: got valid %b, expected no valid", bus.ser_out_valid);
        end else begin
          e = expQ.pop_front();
          checkOutput("validPort", 32'(bus.ser_out_valid), 32'(1 << e.port));
          checkOutput("serOutBit", 32'(bus.ser_out[e.port]), 32'(e.bitVal));
        end
      end
      if (bus.done) begin
        if (expQ.size() == 0 || !expQ[0].isDone) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedDone: got done=1, expected done=0");
        end else begin
          e = expQ.pop_front();
          checkOutput("donePortSel", 32'(bus.port_sel), 32'(e.port));
          checkOutput("doneBusyLow", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One enabled edge carrying bit b, followed by gap disabled clocks.
  task automatic applyStimulus(input logic b, input int gap);
    bus.ser_in = b;
    bus.clk_en = 1'b1;
    @(posedge clk);
    #2;
    bus.clk_en = 1'b0;
    bus.ser_in = 1'b1;
    repeat (gap) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Idle-level enabled edges; a stuck parser would emit events here.
  task automatic idleBits(input int n);
    bus.ser_in = 1'b1;
    bus.clk_en = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    bus.clk_en = 1'b0;
  endtask

  // Sends start + address + length + nPayload payload bits, pushing the
  // expected events first. done is expected only when the frame completes.
  task automatic sendFrame(input int port, input int len, input logic [15:0] data,
                           input int gap, input int nPayload);
    logic [31:0] p;
    logic [31:0] l;
    expEvent_t e;
    p = 32'(port);
    l = 32'(len);
    for (int i = 0; i < nPayload; i++) begin
      e.isDone = 1'b0;
      e.port   = port;
      e.bitVal = data[len-1-i];
      expQ.push_back(e);
    end
    if (nPayload == len) begin
      e.isDone = 1'b1;
      e.port   = port;
      e.bitVal = 1'b0;
      expQ.push_back(e);
    end
    applyStimulus(1'b0, gap);
    for (int i = 0; i < PORT_W; i++) applyStimulus(p[PORT_W-1-i], gap);
    for (int i = 0; i < LEN_W; i++) applyStimulus(l[LEN_W-1-i], gap);
    for (int i = 0; i < nPayload; i++) applyStimulus(data[len-1-i], gap);
  endtask

  initial begin
    reset      = 1'b0;
    bus.ser_in = 1'b1;
    bus.clk_en = 1'b0;
    bus.abort  = 1'b0;

    #12;
    checkOutput("resetBusy", 32'(bus.busy), 32'd0);
    checkOutput("resetDone", 32'(bus.done), 32'd0);
    checkOutput("resetPortSel", 32'(bus.port_sel), 32'd0);
    checkOutput("resetSerOut", 32'(bus.ser_out), 32'd0);
    checkOutput("resetValid", 32'(bus.ser_out_valid), 32'd0);
    #11;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    $display("[TB] basic frame, port 2, payload 101, strobe every 4th clock");
    sendFrame(2, 3, 16'b101, 3, 3);
    idleBits(2);
    checkOutput("basicPortSel", 32'(bus.port_sel), 32'h2);
    checkOutput("basicBusy", 32'(bus.busy), 32'd0);
    checkOutput("basicSerOut", 32'(bus.ser_out), 32'b0100);

    $display("[TB] zero-length frame on port 1");
    sendFrame(1, 0, 16'h0, 1, 0);
    checkOutput("zeroBusy", 32'(bus.busy), 32'd0);
    idleBits(2);
    checkOutput("zeroPortSel", 32'(bus.port_sel), 32'h1);
    checkOutput("zeroSerOutHold", 32'(bus.ser_out), 32'b0100);

    $display("[TB] back-to-back frames, port 3 then port 0");
    sendFrame(3, 1, 16'b1, 0, 1);
    sendFrame(0, 2, 16'b01, 0, 2);
    idleBits(2);
    checkOutput("b2bSerOut", 32'(bus.ser_out), 32'b1101);
    checkOutput("b2bPortSel", 32'(bus.port_sel), 32'h0);

    $display("[TB] abort after two payload bits of a length-5 frame");
    sendFrame(1, 5, 16'b10110, 1, 2);
    checkOutput("abortBusyBefore", 32'(bus.busy), 32'd1);
    bus.abort  = 1'b1;
    bus.clk_en = 1'b1;
    bus.ser_in = 1'b1;
    @(posedge clk);
    #2;
    bus.abort  = 1'b0;
    bus.clk_en = 1'b0;
    checkOutput("abortBusyAfter", 32'(bus.busy), 32'd0);
    checkOutput("abortSerOutHold", 32'(bus.ser_out), 32'b1101);
    checkOutput("abortPortSelHold", 32'(bus.port_sel), 32'h1);
    idleBits(6);
    sendFrame(1, 3, 16'b011, 1, 3);
    idleBits(2);
    checkOutput("postAbortSerOut", 32'(bus.ser_out), 32'b1111);

    $display("[TB] async reset during length field with strobe low");
    applyStimulus(1'b0, 0);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 0);
    checkOutput("midLenBusy", 32'(bus.busy), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("asyncBusy", 32'(bus.busy), 32'd0);
    checkOutput("asyncPortSel", 32'(bus.port_sel), 32'd0);
    checkOutput("asyncSerOut", 32'(bus.ser_out), 32'd0);
    checkOutput("asyncValid", 32'(bus.ser_out_valid), 32'd0);
    checkOutput("asyncDone", 32'(bus.done), 32'd0);
    #8;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    sendFrame(1, 15, 16'b101100111000111, 1, 15);
    idleBits(2);
    checkOutput("longSerOut", 32'(bus.ser_out), 32'b0010);
    checkOutput("longPortSel", 32'(bus.port_sel), 32'h1);

    idleBits(5);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
